// File: rtl/burst_pkg.sv
// Shared definitions for the burst master: state encoding, field widths,
// packed-bus bit positions and helpers that build the address-channel words.
package burst_pkg;

  localparam int ADDR_W  = 8;
  localparam int LEN_W   = 4;
  localparam int ID_W    = 4;
  localparam int DATA_W  = 8;

  // Packed bus widths
  localparam int ARIN_W  = ADDR_W + LEN_W + ID_W;  // {addr, len, id}
  localparam int AWIN_W  = ADDR_W + ID_W;          // {addr, id}
  localparam int BRESP_W = 1 + ID_W;               // {err, id}
  localparam int RDATA_W = DATA_W + 1;             // {data, err}

  // Bit positions inside the packed buses
  localparam int ARIN_ID_LSB    = 0;
  localparam int ARIN_LEN_LSB   = ID_W;
  localparam int ARIN_ADDR_LSB  = ID_W + LEN_W;
  localparam int AWIN_ID_LSB    = 0;
  localparam int AWIN_ADDR_LSB  = ID_W;
  localparam int BRESP_ID_LSB   = 0;
  localparam int BRESP_ERR_BIT  = ID_W;
  localparam int RDATA_ERR_BIT  = 0;
  localparam int RDATA_DATA_LSB = 1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_AW   = 3'd3,
    ST_W    = 3'd4,
    ST_B    = 3'd5,
    ST_DONE = 3'd6
  } burst_state_t;

  function automatic logic [ARIN_W-1:0] pack_arin(
    input logic [ADDR_W-1:0] addr,
    input logic [LEN_W-1:0]  len,
    input logic [ID_W-1:0]   id
  );
    logic [ARIN_W-1:0] v;
    v = '0;
    v[ARIN_ADDR_LSB +: ADDR_W] = addr;
    v[ARIN_LEN_LSB  +: LEN_W]  = len;
    v[ARIN_ID_LSB   +: ID_W]   = id;
    return v;
  endfunction

  function automatic logic [AWIN_W-1:0] pack_awin(
    input logic [ADDR_W-1:0] addr,
    input logic [ID_W-1:0]   id
  );
    logic [AWIN_W-1:0] v;
    v = '0;
    v[AWIN_ADDR_LSB +: ADDR_W] = addr;
    v[AWIN_ID_LSB   +: ID_W]   = id;
    return v;
  endfunction

endpackage

// File: rtl/burst_watchdog.sv
// Stall watchdog: counts cycles spent in an active state without progress.
// Cleared whenever the owner reports progress or a state change; flags expiry
// once TIMEOUT stall cycles have accumulated.
module burst_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_active,
  input  logic i_clear,
  output logic o_expired
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] r_count;

  // Stall counter: reset on idle/clear, saturates at the limit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (!i_active || i_clear) begin
      r_count <= '0;
    end else if (r_count != LIMIT) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_expired = i_active && (r_count == LIMIT);

endmodule

// File: rtl/burst_master.sv
// Burst master: accepts one host command at a time and runs it as a read
// (AR then R beats) or a write (AW, W beats, B response) on the slave side.
// Every active state is guarded by a stall watchdog that aborts to DONE
// with an error when the slave stops making progress.
module burst_master
  import burst_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  // host command
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_write,
  input  logic [ADDR_W-1:0]  cmd_addr,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [ID_W-1:0]    cmd_id,
  // host write data
  input  logic [DATA_W-1:0]  wr_data,
  input  logic               wr_valid,
  output logic               wr_ready,
  // host read data and completion
  output logic [DATA_W-1:0]  rd_data,
  output logic               rd_valid,
  output logic               done,
  output logic               done_err,
  // slave read address
  output logic               ARVALID,
  input  logic               ARREADY,
  output logic [ARIN_W-1:0]  ARIN,
  // slave read data
  input  logic               RVALID,
  output logic               RREADY,
  input  logic               RLAST,
  input  logic [RDATA_W-1:0] RDATA,
  // slave write address
  output logic               AWVALID,
  input  logic               AWREADY,
  output logic [AWIN_W-1:0]  AWIN,
  // slave write data
  output logic               WVALID,
  input  logic               WREADY,
  output logic               WLAST,
  output logic [DATA_W-1:0]  WDATA,
  // slave write response
  input  logic               BVALID,
  output logic               BREADY,
  input  logic [BRESP_W-1:0] BRESP
);

  burst_state_t r_state;
  burst_state_t w_state_next;

  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_len;
  logic [ID_W-1:0]   r_id;
  logic [LEN_W-1:0]  r_beat;
  logic              r_err;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;

  logic w_accept;
  logic w_r_hs;
  logic w_w_hs;
  logic w_b_hs;
  logic w_last_beat;
  logic w_active;
  logic w_progress;
  logic w_clear;
  logic w_expired;
  logic w_b_err;

  // The beat about to transfer is the final one of the burst
  assign w_last_beat = (r_beat == r_len);

  assign w_active   = (r_state inside {ST_AR, ST_R, ST_AW, ST_W, ST_B});
  // Handshakes that do not change state still count as forward progress
  assign w_progress = w_r_hs || w_w_hs;
  assign w_clear    = (w_state_next != r_state) || w_progress;

  // Write response is bad if the slave flags it or echoes a foreign ID
  assign w_b_err = BRESP[BRESP_ERR_BIT] ||
                   (BRESP[BRESP_ID_LSB +: ID_W] != r_id);

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;

  burst_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .i_active  (w_active),
    .i_clear   (w_clear),
    .o_expired (w_expired)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and bus outputs; a watchdog expiry overrides everything
  always_comb begin
    w_state_next = r_state;
    cmd_ready    = 1'b0;
    wr_ready     = 1'b0;
    done         = 1'b0;
    done_err     = 1'b0;
    ARVALID      = 1'b0;
    ARIN         = '0;
    RREADY       = 1'b0;
    AWVALID      = 1'b0;
    AWIN         = '0;
    WVALID       = 1'b0;
    WLAST        = 1'b0;
    WDATA        = '0;
    BREADY       = 1'b0;
    w_accept     = 1'b0;
    w_r_hs       = 1'b0;
    w_w_hs       = 1'b0;
    w_b_hs       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // Held low while reset is asserted so all outputs read zero
        cmd_ready = !rst;
        w_accept  = cmd_valid && !rst;
        if (w_accept) begin
          w_state_next = cmd_write ? ST_AW : ST_AR;
        end
      end

      ST_AR: begin
        ARVALID = 1'b1;
        ARIN    = pack_arin(r_addr, r_len, r_id);
        if (ARREADY) begin
          w_state_next = ST_R;
        end
      end

      ST_R: begin
        RREADY = 1'b1;
        if (RVALID) begin
          w_r_hs = 1'b1;
          if (RLAST || w_last_beat) begin
            w_state_next = ST_DONE;
          end
        end
      end

      ST_AW: begin
        AWVALID = 1'b1;
        AWIN    = pack_awin(r_addr, r_id);
        if (AWREADY) begin
          w_state_next = ST_W;
        end
      end

      ST_W: begin
        WVALID = wr_valid;
        WDATA  = wr_valid ? wr_data : '0;
        WLAST  = w_last_beat;
        if (wr_valid && WREADY) begin
          w_w_hs   = 1'b1;
          wr_ready = 1'b1;
          if (w_last_beat) begin
            w_state_next = ST_B;
          end
        end
      end

      ST_B: begin
        BREADY = 1'b1;
        if (BVALID) begin
          w_b_hs       = 1'b1;
          w_state_next = ST_DONE;
        end
      end

      ST_DONE: begin
        done         = 1'b1;
        done_err     = r_err;
        w_state_next = ST_IDLE;
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    if (w_expired) begin
      ARVALID      = 1'b0;
      ARIN         = '0;
      RREADY       = 1'b0;
      AWVALID      = 1'b0;
      AWIN         = '0;
      WVALID       = 1'b0;
      WLAST        = 1'b0;
      WDATA        = '0;
      wr_ready     = 1'b0;
      BREADY       = 1'b0;
      w_r_hs       = 1'b0;
      w_w_hs       = 1'b0;
      w_b_hs       = 1'b0;
      w_state_next = ST_DONE;
    end
  end

  // Command latch, beat counter, error accumulation and read-beat register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr     <= '0;
      r_len      <= '0;
      r_id       <= '0;
      r_beat     <= '0;
      r_err      <= 1'b0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      if (w_accept) begin
        r_addr <= cmd_addr;
        r_len  <= cmd_len;
        r_id   <= cmd_id;
        r_beat <= '0;
        r_err  <= 1'b0;
      end
      if (w_r_hs) begin
        r_rd_data  <= RDATA[RDATA_DATA_LSB +: DATA_W];
        r_rd_valid <= 1'b1;
        r_beat     <= r_beat + LEN_W'(1);
        r_err      <= r_err | RDATA[RDATA_ERR_BIT];
      end
      if (w_w_hs) begin
        r_beat <= r_beat + LEN_W'(1);
      end
      if (w_b_hs) begin
        r_err <= w_b_err;
      end
      if (w_expired) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_burst_master.sv
// Testbench for burst_master: a table of read/write bursts driven through a
// simple slave model, with read beats and completion status checked against
// scoreboard queues, plus hand-written timeout and mid-burst reset sequences.
module tb_burst_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_write;
  logic [7:0]  cmd_addr;
  logic [3:0]  cmd_len, cmd_id;
  logic [7:0]  wr_data;
  logic        wr_valid;
  logic        cmd_ready, wr_ready, rd_valid, done, done_err;
  logic [7:0]  rd_data;
  logic        ARVALID, ARREADY, RVALID, RREADY, RLAST;
  logic [15:0] ARIN;
  logic [8:0]  RDATA;
  logic        AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY;
  logic [11:0] AWIN;
  logic [7:0]  WDATA;
  logic [4:0]  BRESP;

  always #5 clk = ~clk;

  burst_master #(.TIMEOUT(255)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .done_err(done_err),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARIN(ARIN),
    .RVALID(RVALID), .RREADY(RREADY), .RLAST(RLAST), .RDATA(RDATA),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWIN(AWIN),
    .WVALID(WVALID), .WREADY(WREADY), .WLAST(WLAST), .WDATA(WDATA),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP)
  );

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [3:0]  len;
    logic [3:0]  id;
    logic [31:0] data;      // beat k in data[8k+:8]
    logic [3:0]  err_mask;  // read: slave err bit per beat
    logic [4:0]  bresp;     // write: slave response
    logic [15:0] exp_hdr;   // expected ARIN or AWIN
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];

  int checks   = 0;
  int failures = 0;
  int rd_count = 0;
  logic [7:0] rd_q[$];
  logic       done_q[$];
  logic [7:0] mon_exp;
  logic       mon_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: read beats and completion pulses
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      rd_count++;
      if (rd_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd_extra: got beat 0x%0h expected none", rd_data);
      end else begin
        mon_exp = rd_q.pop_front();
        check("rd_data", 32'(rd_data), 32'(mon_exp));
      end
    end
    if (done === 1'b1) begin
      if (done_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 expected 0");
      end else begin
        mon_err = done_q.pop_front();
        check("done_err", 32'(done_err), 32'(mon_err));
      end
    end
  end

  task automatic wait_done();
    int cyc;
    cyc = 0;
    while (done_q.size() != 0 && cyc < 50) begin
      @(posedge clk);
      cyc++;
    end
    check("done_seen_pending", 32'(done_q.size()), 32'd0);
    done_q.delete();
    @(negedge clk);
  endtask

  task automatic issue_cmd(input vec_t v);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = v.wr;
    cmd_addr  = v.addr;
    cmd_len   = v.len;
    cmd_id    = v.id;
    #1 check("cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic do_read(input vec_t v);
    int n;
    n = int'(v.len) + 1;
    for (int k = 0; k < n; k++) rd_q.push_back(v.data[8*k +: 8]);
    done_q.push_back(v.exp_err);
    rd_count = 0;
    issue_cmd(v);
    #1;
    check("arvalid", 32'(ARVALID), 32'd1);
    check("arin", 32'(ARIN), 32'(v.exp_hdr));
    ARREADY = 1'b1;
    @(negedge clk);
    ARREADY = 1'b0;
    #1 check("ar_drop_rready", 32'({ARVALID, RREADY}), 32'd1);
    for (int k = 0; k < n; k++) begin
      if (k == 1) begin
        RVALID = 1'b0;
        @(negedge clk);
      end
      RVALID = 1'b1;
      RDATA  = {v.data[8*k +: 8], v.err_mask[k]};
      RLAST  = (k == n - 1);
      @(negedge clk);
    end
    RVALID = 1'b0;
    RLAST  = 1'b0;
    RDATA  = '0;
    wait_done();
    check("rd_count", 32'(rd_count), 32'(n));
    check("rd_q_empty", 32'(rd_q.size()), 32'd0);
    rd_q.delete();
  endtask

  task automatic do_write(input vec_t v);
    int n;
    n = int'(v.len) + 1;
    done_q.push_back(v.exp_err);
    issue_cmd(v);
    #1;
    check("awvalid", 32'(AWVALID), 32'd1);
    check("awin", 32'(AWIN), 32'(v.exp_hdr[11:0]));
    AWREADY = 1'b1;
    @(negedge clk);
    AWREADY = 1'b0;
    #1 check("aw_drop", 32'(AWVALID), 32'd0);
    for (int k = 0; k < n; k++) begin
      if (k == 1) begin
        wr_valid = 1'b1;
        wr_data  = v.data[15:8];
        WREADY   = 1'b0;
        #1 check("w_stall_ready", 32'(wr_ready), 32'd0);
        @(negedge clk);
      end
      wr_valid = 1'b1;
      wr_data  = v.data[8*k +: 8];
      WREADY   = 1'b1;
      #1;
      check("wr_ready", 32'(wr_ready), 32'd1);
      check("wdata", 32'(WDATA), 32'(v.data[8*k +: 8]));
      check("wlast", 32'(WLAST), 32'(k == n - 1));
      @(negedge clk);
    end
    wr_valid = 1'b0;
    WREADY   = 1'b0;
    #1 check("bready", 32'(BREADY), 32'd1);
    BVALID = 1'b1;
    BRESP  = v.bresp;
    @(negedge clk);
    BVALID = 1'b0;
    BRESP  = '0;
    wait_done();
  endtask

  function automatic logic [10:0] flags();
    return {cmd_ready, wr_ready, rd_valid, done, done_err, ARVALID,
            RREADY, AWVALID, WVALID, WLAST, BREADY};
  endfunction

  initial begin
    #400000;
    $display("FAIL tb_timeout: got no finish expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    vec_t tv;
    int   cnt;

    //          wr    addr   len   id    data          errm     bresp  hdr       err
    vecs[0] = '{1'b0, 8'h10, 4'd3, 4'h5, 32'hA4A3A2A1, 4'b0000, 5'h00, 16'h1035, 1'b0};
    vecs[1] = '{1'b1, 8'h20, 4'd1, 4'h9, 32'h00006655, 4'b0000, 5'h09, 16'h0209, 1'b0};
    vecs[2] = '{1'b0, 8'hFE, 4'd3, 4'h2, 32'h14131211, 4'b1100, 5'h00, 16'hFE32, 1'b1};
    vecs[3] = '{1'b1, 8'h30, 4'd2, 4'hA, 32'h00030201, 4'b0000, 5'h1A, 16'h030A, 1'b1};
    vecs[4] = '{1'b1, 8'h44, 4'd0, 4'h3, 32'h00000077, 4'b0000, 5'h03, 16'h0443, 1'b0};
    vecs[5] = '{1'b0, 8'h80, 4'd0, 4'hF, 32'h000000C3, 4'b0000, 5'h00, 16'h800F, 1'b0};
    vecs[6] = '{1'b1, 8'h50, 4'd0, 4'h4, 32'h00000099, 4'b0000, 5'h05, 16'h0504, 1'b1};
    vecs[7] = '{1'b1, 8'h60, 4'd0, 4'h6, 32'h000000AB, 4'b0000, 5'h16, 16'h0606, 1'b1};

    rst = 1'b1;
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0; cmd_id = 0;
    wr_data = 0; wr_valid = 0; ARREADY = 0; RVALID = 0; RLAST = 0; RDATA = 0;
    AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0;

    // Reset state
    repeat (3) @(negedge clk);
    #1 check("reset_flags_during", 32'(flags()), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_flags_after", 32'(flags()), 32'h400);
    check("reset_buses", {rd_data, WDATA, ARIN}, 32'd0);
    check("reset_awin", 32'(AWIN), 32'd0);

    // Table-driven bursts
    for (int i = 0; i < 8; i++) begin
      $display("txn %0d: %s addr=0x%02h len=%0d id=0x%0h expect_err=%0b",
               i, vecs[i].wr ? "write" : "read ", vecs[i].addr, vecs[i].len,
               vecs[i].id, vecs[i].exp_err);
      if (vecs[i].wr) do_write(vecs[i]);
      else            do_read(vecs[i]);
    end

    // Slave never accepts the read address: watchdog abort
    tv = '{1'b0, 8'h90, 4'd0, 4'h1, 32'h0, 4'b0000, 5'h00, 16'h9001, 1'b1};
    $display("txn 8: read  addr=0x90 ARREADY stuck low, expect timeout err=1");
    done_q.push_back(1'b1);
    issue_cmd(tv);
    cnt = 0;
    for (int c = 0; c < 400; c++) begin
      #1;
      if (ARVALID) cnt++;
      if (done) break;
      @(negedge clk);
    end
    check("timeout_arvalid_cycles", 32'(cnt), 32'd255);
    wait_done();

    // Reset during beat 2 of a 4-beat write
    tv = '{1'b1, 8'h70, 4'd3, 4'h7, 32'h44332211, 4'b0000, 5'h07, 16'h0707, 1'b0};
    $display("txn 9: write addr=0x70 len=3 id=0x7 reset during beat 2, expect no done");
    issue_cmd(tv);
    #1 check("rst_awvalid", 32'(AWVALID), 32'd1);
    AWREADY = 1'b1;
    @(negedge clk);
    AWREADY  = 1'b0;
    wr_valid = 1'b1;
    wr_data  = 8'h11;
    WREADY   = 1'b1;
    #1 check("rst_beat1_ready", 32'(wr_ready), 32'd1);
    @(negedge clk);
    wr_data = 8'h22;
    #1 check("rst_beat2_wdata", 32'(WDATA), 32'h22);
    rst = 1'b1;
    #1;
    check("rst_mid_flags", 32'(flags()), 32'd0);
    check("rst_mid_buses", {rd_data, WDATA, ARIN}, 32'd0);
    check("rst_mid_awin", 32'(AWIN), 32'd0);
    @(negedge clk);
    rst      = 1'b0;
    wr_valid = 1'b0;
    WREADY   = 1'b0;
    #1 check("rst_release_flags", 32'(flags()), 32'h400);
    repeat (4) @(negedge clk);

    // Next command after the abandoned burst
    $display("txn 10: read  addr=0x10 len=3 id=0x5 after reset, expect_err=0");
    do_read(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
